// File: rtl/rom_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rom_port_arbiter_pkg
//   Shared constants and helpers for the dual-port ROM read arbiter.
//   MAX_NUM_REQ  : largest requester count the arbiter is built for
//   ROM_RD_LAT   : read latency of the block ROM (address in T, data in T+1)
//   MAX_IDX_W    : index width sufficient for MAX_NUM_REQ requesters
//   rpa_clog2()  : ceil(log2(v)) for sizing requester indices
// -----------------------------------------------------------------------------
package rom_port_arbiter_pkg;

   localparam int MAX_NUM_REQ = 8;
   localparam int ROM_RD_LAT  = 1;

   function automatic int rpa_clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   localparam int MAX_IDX_W = rpa_clog2(MAX_NUM_REQ);

endpackage

// File: rtl/rom_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// rom_port_arbiter_if
//   Requester-side bus of the ROM port arbiter.
//   req_valid : per-requester read request
//   req_addr  : flattened addresses, requester i at [i*ADDRESS_WIDTH +: ADDRESS_WIDTH]
//   req_ready : request accepted this cycle
//   rsp_valid : read data for requester i valid this cycle
//   rsp_data  : flattened signed ROM words, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   master modport = requesters, slave modport = arbiter.
// -----------------------------------------------------------------------------
interface rom_port_arbiter_if #(
   parameter int NUM_REQ       = 4,
   parameter int ADDRESS_WIDTH = 7,
   parameter int DATA_WIDTH    = 16
);
   logic [NUM_REQ-1:0]               req_valid;
   logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr;
   logic [NUM_REQ-1:0]               req_ready;
   logic [NUM_REQ-1:0]               rsp_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0]    rsp_data;

   modport master (
      output req_valid,
      output req_addr,
      input  req_ready,
      input  rsp_valid,
      input  rsp_data
   );

   modport slave (
      input  req_valid,
      input  req_addr,
      output req_ready,
      output rsp_valid,
      output rsp_data
   );
endinterface

// File: rtl/rom_port_arbiter_rr_dual_pick.sv
// -----------------------------------------------------------------------------
// rr_dual_pick
//   Combinational round-robin selector returning the first two active requests
//   found when scanning valid_i upward from ptr_i (modulo NUM_REQ).
//   valid_i          : request vector
//   ptr_i            : scan start index (< NUM_REQ)
//   g1_found_o/g2_*  : a first / second request was found
//   g1_idx_o/g2_idx_o: requester index of each pick
//   g1_oh_o/g2_oh_o  : one-hot form of each pick (zero when not found)
// -----------------------------------------------------------------------------
module rr_dual_pick #(
   parameter int NUM_REQ   = 4,
   parameter int IDX_WIDTH = 3
) (
   input  logic [NUM_REQ-1:0]   valid_i,
   input  logic [IDX_WIDTH-1:0] ptr_i,
   output logic                 g1_found_o,
   output logic                 g2_found_o,
   output logic [IDX_WIDTH-1:0] g1_idx_o,
   output logic [IDX_WIDTH-1:0] g2_idx_o,
   output logic [NUM_REQ-1:0]   g1_oh_o,
   output logic [NUM_REQ-1:0]   g2_oh_o
);

   logic [NUM_REQ-1:0] rot;
   int                 k1;
   int                 k2;
   int                 s1;
   int                 s2;

   always_comb begin
      // Rotate so that bit 0 of rot is the requester at ptr_i.
      rot        = NUM_REQ'({valid_i, valid_i} >> ptr_i);
      g1_found_o = 1'b0;
      g2_found_o = 1'b0;
      k1         = 0;
      k2         = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (rot[k]) begin
            if (!g1_found_o) begin
               g1_found_o = 1'b1;
               k1         = k;
            end else if (!g2_found_o) begin
               g2_found_o = 1'b1;
               k2         = k;
            end
         end
      end
      // Un-rotate: rotated position k maps back to (ptr + k) mod NUM_REQ.
      s1 = int'(ptr_i) + k1;
      if (s1 >= NUM_REQ) s1 = s1 - NUM_REQ;
      s2 = int'(ptr_i) + k2;
      if (s2 >= NUM_REQ) s2 = s2 - NUM_REQ;
      g1_idx_o = IDX_WIDTH'(s1);
      g2_idx_o = IDX_WIDTH'(s2);
      g1_oh_o  = g1_found_o ? (NUM_REQ'(1) << g1_idx_o) : '0;
      g2_oh_o  = g2_found_o ? (NUM_REQ'(1) << g2_idx_o) : '0;
   end

endmodule

// File: rtl/rom_port_arbiter.sv
// -----------------------------------------------------------------------------
// rom_port_arbiter
//   Shares the two read ports of a dual-port block ROM among NUM_REQ requesters,
//   granting up to two requests per cycle in round-robin order. Port 1 serves the
//   first pick, port 2 the second; ROM data returns one cycle later and is routed
//   back to the requesters that were granted.
//   clk, rst            : clock (also the ROM clock), async active-high reset
//   req_bus (slave)     : requester handshake and response bus
//   rom_en1/rom_addr1   : ROM port 1 read enable / address
//   rom_en2/rom_addr2   : ROM port 2 read enable / address
//   rom_do1/rom_do2     : ROM port 1 / 2 read data (valid the cycle after enable)
// -----------------------------------------------------------------------------
module rom_port_arbiter
   import rom_port_arbiter_pkg::*;
#(
   parameter int NUM_REQ       = 4,
   parameter int ADDRESS_WIDTH = 7,
   parameter int DATA_WIDTH    = 16,
   parameter int IDX_WIDTH     = 3
) (
   input  logic                         clk,
   input  logic                         rst,
   rom_port_arbiter_if.slave            req_bus,
   output logic                         rom_en1,
   output logic [ADDRESS_WIDTH-1:0]     rom_addr1,
   output logic                         rom_en2,
   output logic [ADDRESS_WIDTH-1:0]     rom_addr2,
   input  logic signed [DATA_WIDTH-1:0] rom_do1,
   input  logic signed [DATA_WIDTH-1:0] rom_do2
);

   localparam int RSP_W = NUM_REQ * DATA_WIDTH;

   logic                 g1_found, g2_found;
   logic                 g1_ok, g2_ok;
   logic [IDX_WIDTH-1:0] g1_idx, g2_idx;
   logic [NUM_REQ-1:0]   g1_oh, g2_oh;

   logic [IDX_WIDTH-1:0] ptr_q, ptr_d;
   logic                 gnt1_vld_q, gnt2_vld_q;
   logic [IDX_WIDTH-1:0] gnt1_idx_q, gnt2_idx_q;

   logic [NUM_REQ-1:0]   rsp_vld;
   logic [RSP_W-1:0]     rsp_dat;

   function automatic logic [IDX_WIDTH-1:0] wrap_inc(input logic [IDX_WIDTH-1:0] x);
      if (int'(x) == NUM_REQ - 1) return '0;
      return x + 1'b1;
   endfunction

   rr_dual_pick #(
      .NUM_REQ   (NUM_REQ),
      .IDX_WIDTH (IDX_WIDTH)
   ) u_pick (
      .valid_i    (req_bus.req_valid),
      .ptr_i      (ptr_q),
      .g1_found_o (g1_found),
      .g2_found_o (g2_found),
      .g1_idx_o   (g1_idx),
      .g2_idx_o   (g2_idx),
      .g1_oh_o    (g1_oh),
      .g2_oh_o    (g2_oh)
   );

   // No grants while reset is held, so the ROM stays idle and nothing is accepted.
   assign g1_ok = g1_found & ~rst;
   assign g2_ok = g2_found & ~rst;

   assign req_bus.req_ready = rst ? '0 : (g1_oh | g2_oh);

   // ---- Stage T: ROM address muxes (idle port address held at 0) ----
   assign rom_en1   = g1_ok;
   assign rom_addr1 = g1_ok ? ADDRESS_WIDTH'(req_bus.req_addr >> (int'(g1_idx) * ADDRESS_WIDTH)) : '0;
   assign rom_en2   = g2_ok;
   assign rom_addr2 = g2_ok ? ADDRESS_WIDTH'(req_bus.req_addr >> (int'(g2_idx) * ADDRESS_WIDTH)) : '0;

   // Resume scanning just past the last requester served this cycle.
   always_comb begin
      ptr_d = ptr_q;
      if (g2_ok)      ptr_d = wrap_inc(g2_idx);
      else if (g1_ok) ptr_d = wrap_inc(g1_idx);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q      <= '0;
         gnt1_vld_q <= 1'b0;
         gnt2_vld_q <= 1'b0;
         gnt1_idx_q <= '0;
         gnt2_idx_q <= '0;
      end else begin
         ptr_q      <= ptr_d;
         gnt1_vld_q <= g1_ok;
         gnt2_vld_q <= g2_ok;
         gnt1_idx_q <= g1_idx;
         gnt2_idx_q <= g2_idx;
      end
   end

   // ---- Stage T+1: route ROM data back to the granted requesters ----
   // The two grant indices always differ, so OR-merging the slices is safe.
   always_comb begin
      rsp_vld = '0;
      rsp_dat = '0;
      if (gnt1_vld_q) begin
         rsp_vld = rsp_vld | (NUM_REQ'(1) << gnt1_idx_q);
         rsp_dat = rsp_dat | (RSP_W'($unsigned(rom_do1)) << (int'(gnt1_idx_q) * DATA_WIDTH));
      end
      if (gnt2_vld_q) begin
         rsp_vld = rsp_vld | (NUM_REQ'(1) << gnt2_idx_q);
         rsp_dat = rsp_dat | (RSP_W'($unsigned(rom_do2)) << (int'(gnt2_idx_q) * DATA_WIDTH));
      end
   end

   assign req_bus.rsp_valid = rsp_vld;
   assign req_bus.rsp_data  = rsp_dat;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rom_port_arbiter
//   Directed scenarios followed by a random soak. A behavioural ROM answers the
//   DUT's port reads; a reference model scans requesters round-robin with plain
//   integer arithmetic and predicts grants, ROM port drive and responses.
// -----------------------------------------------------------------------------
module tb_rom_port_arbiter;

   localparam int N   = 4;
   localparam int AW  = 7;
   localparam int DW  = 16;
   localparam int IW  = 3;
   localparam int AWT = N * AW;
   localparam int DWT = N * DW;

   logic                 clk;
   logic                 rst;
   logic                 rom_en1, rom_en2;
   logic [AW-1:0]        rom_addr1, rom_addr2;
   logic signed [DW-1:0] rom_do1, rom_do2;

   logic [DW-1:0] rom_mem [0:(1<<AW)-1];

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   int            m_ptr;
   logic [N-1:0]  m_pend_vld;
   logic [AW-1:0] m_pend_addr [N];
   logic [N-1:0]  m_last_gnt;
   int            wait_cnt [N];
   int            n_acc, n_rsp, n_drop;

   rom_port_arbiter_if #(.NUM_REQ(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   rom_port_arbiter #(
      .NUM_REQ       (N),
      .ADDRESS_WIDTH (AW),
      .DATA_WIDTH    (DW),
      .IDX_WIDTH     (IW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_bus   (bus),
      .rom_en1   (rom_en1),
      .rom_addr1 (rom_addr1),
      .rom_en2   (rom_en2),
      .rom_addr2 (rom_addr2),
      .rom_do1   (rom_do1),
      .rom_do2   (rom_do2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Dual-port ROM without output register
   always @(posedge clk) begin
      if (rom_en1) rom_do1 <= rom_mem[rom_addr1];
      if (rom_en2) rom_do2 <= rom_mem[rom_addr2];
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [AW-1:0] addr_of(input int i);
      return AW'(bus.req_addr >> (i * AW));
   endfunction

   function automatic logic [DW-1:0] rsp_of(input int i);
      return DW'(bus.rsp_data >> (i * DW));
   endfunction

   task automatic set_addr(input int i, input logic [AW-1:0] a);
      logic [AWT-1:0] mask;
      mask = AWT'({AW{1'b1}}) << (i * AW);
      bus.req_addr = (bus.req_addr & ~mask) | (AWT'(a) << (i * AW));
   endtask

   // Predict and compare this cycle's outputs, then advance the model.
   task automatic model_step();
      logic [N-1:0]   exp_rdy;
      logic [DWT-1:0] exp_rd;
      int             g1, g2, idx;
      if (rst) begin
         check("rst_ready", bus.req_ready, '0);
         check("rst_en1", rom_en1, 1'b0);
         check("rst_en2", rom_en2, 1'b0);
         check("rst_rsp_valid", bus.rsp_valid, '0);
         check("rst_rsp_data", bus.rsp_data, '0);
         n_drop     += $countones(m_pend_vld);
         m_ptr      = 0;
         m_pend_vld = '0;
         m_last_gnt = '0;
         for (int i = 0; i < N; i++) wait_cnt[i] = 0;
         return;
      end
      exp_rd = '0;
      for (int i = 0; i < N; i++)
         if (m_pend_vld[i]) exp_rd = exp_rd | (DWT'(rom_mem[m_pend_addr[i]]) << (i * DW));
      check("rsp_valid", bus.rsp_valid, m_pend_vld);
      check("rsp_data", bus.rsp_data, exp_rd);
      n_rsp += $countones(bus.rsp_valid);

      g1 = -1;
      g2 = -1;
      for (int k = 0; k < N; k++) begin
         idx = (m_ptr + k) % N;
         if (bus.req_valid[idx]) begin
            if (g1 < 0)      g1 = idx;
            else if (g2 < 0) g2 = idx;
         end
      end
      exp_rdy = '0;
      if (g1 >= 0) exp_rdy[g1] = 1'b1;
      if (g2 >= 0) exp_rdy[g2] = 1'b1;
      check("req_ready", bus.req_ready, exp_rdy);
      check("rom_en1", rom_en1, g1 >= 0);
      check("rom_addr1", rom_addr1, (g1 >= 0) ? addr_of(g1) : '0);
      check("rom_en2", rom_en2, g2 >= 0);
      check("rom_addr2", rom_addr2, (g2 >= 0) ? addr_of(g2) : '0);

      for (int i = 0; i < N; i++) begin
         if (bus.req_ready[i]) check("no_starve", wait_cnt[i] <= N / 2, 1'b1);
         if (bus.req_valid[i] && !bus.req_ready[i]) wait_cnt[i]++;
         else                                       wait_cnt[i] = 0;
      end

      m_pend_vld = exp_rdy;
      for (int i = 0; i < N; i++) m_pend_addr[i] = addr_of(i);
      m_last_gnt = exp_rdy;
      n_acc += $countones(exp_rdy);
      if (g2 >= 0)      m_ptr = (g2 + 1) % N;
      else if (g1 >= 0) m_ptr = (g1 + 1) % N;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic advance();
      model_step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [N-1:0] all_rdy [4];
      logic [N-1:0] v;
      all_rdy[0] = 4'b0011; all_rdy[1] = 4'b1100; all_rdy[2] = 4'b0011; all_rdy[3] = 4'b1100;

      for (int a = 0; a < (1 << AW); a++) rom_mem[a] = DW'($urandom);
      rom_mem[5]   = 16'h1234;
      rom_mem[127] = 16'h8001;

      m_ptr = 0; m_pend_vld = '0; m_last_gnt = '0;
      n_acc = 0; n_rsp = 0; n_drop = 0;
      for (int i = 0; i < N; i++) begin wait_cnt[i] = 0; m_pend_addr[i] = '0; end

      rst = 1'b1;
      bus.req_valid = '0;
      bus.req_addr  = '0;
      #1;
      repeat (2) begin settle(); advance(); end
      rst = 1'b0;

      // Single requester
      bus.req_valid = 4'b0001;
      set_addr(0, 7'd5);
      settle();
      check("single_ready", bus.req_ready, 4'b0001);
      check("single_en1", rom_en1, 1'b1);
      check("single_addr1", rom_addr1, 7'd5);
      check("single_en2", rom_en2, 1'b0);
      advance();
      bus.req_valid = '0;
      settle();
      check("single_rsp_valid", bus.rsp_valid, 4'b0001);
      check("single_rsp_data", rsp_of(0), 16'h1234);
      advance();

      // Reset pulse so that the pointer starts from 0
      rst = 1'b1; settle(); advance(); rst = 1'b0;

      // All requesters active
      for (int i = 0; i < N; i++) set_addr(i, AW'(10 + i));
      bus.req_valid = 4'b1111;
      for (int c = 0; c < 4; c++) begin
         settle();
         check("all_ready", bus.req_ready, all_rdy[c]);
         check("all_addr1", rom_addr1, (c % 2 == 0) ? 7'd10 : 7'd12);
         check("all_addr2", rom_addr2, (c % 2 == 0) ? 7'd11 : 7'd13);
         advance();
      end
      bus.req_valid = '0;
      settle();
      check("all_last_rsp", bus.rsp_valid, 4'b1100);
      advance();

      // Wrap-around: move ptr to 3, then 1001
      bus.req_valid = 4'b0100;
      settle(); advance();
      bus.req_valid = 4'b1001;
      settle();
      check("wrap_ready", bus.req_ready, 4'b1001);
      check("wrap_addr1", rom_addr1, 7'd13);
      check("wrap_addr2", rom_addr2, 7'd10);
      advance();
      bus.req_valid = 4'b1111;
      settle();
      check("wrap_ptr_next", bus.req_ready, 4'b0110);
      advance();

      // Same address on both ports
      set_addr(1, 7'd127);
      set_addr(2, 7'd127);
      bus.req_valid = 4'b0110;
      settle();
      check("same_en_both", {rom_en1, rom_en2}, 2'b11);
      check("same_addr1", rom_addr1, 7'd127);
      check("same_addr2", rom_addr2, 7'd127);
      advance();
      bus.req_valid = '0;
      settle();
      check("same_rsp_valid", bus.rsp_valid, 4'b0110);
      check("same_rsp1", rsp_of(1), 16'h8001);
      check("same_rsp2", rsp_of(2), 16'h8001);
      advance();

      // Reset in the cycle after a grant
      bus.req_valid = 4'b0011;
      settle(); advance();
      rst = 1'b1;
      bus.req_valid = '0;
      settle();
      check("midrst_rsp_valid", bus.rsp_valid, '0);
      advance();
      rst = 1'b0;
      bus.req_valid = 4'b0010;
      settle();
      check("midrst_ready", bus.req_ready, 4'b0010);
      check("midrst_en1", rom_en1, 1'b1);
      check("midrst_en2", rom_en2, 1'b0);
      advance();
      bus.req_valid = '0;
      settle(); advance();

      // Reset with ptr != 0, then all valid must start at requester 0
      bus.req_valid = 4'b0001;
      settle(); advance();
      rst = 1'b1;
      bus.req_valid = '0;
      settle(); advance();
      rst = 1'b0;
      bus.req_valid = 4'b1111;
      settle();
      check("rst_ptr_zero", bus.req_ready, 4'b0011);
      advance();
      bus.req_valid = '0;
      settle(); advance();

      // Random soak: requests are held until accepted
      for (int c = 0; c < 10000; c++) begin
         v = bus.req_valid;
         for (int i = 0; i < N; i++) begin
            if (!(v[i] && !m_last_gnt[i])) begin
               v[i] = ($urandom_range(0, 99) < 60);
               set_addr(i, ($urandom_range(0, 9) == 0) ? 7'd127 : AW'($urandom_range(0, 127)));
            end
         end
         bus.req_valid = v;
         settle();
         advance();
      end

      bus.req_valid = '0;
      repeat (2) begin settle(); advance(); end
      check("rsp_total", n_rsp, n_acc - n_drop - $countones(m_pend_vld));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
